// File: rtl/fifo_multiplier_stream.sv
// fifo_multiplier_stream
//   DEPTH-entry operand FIFO feeding a sequential shift-add multiplier.
//   Each entry carries {signed_mode, a, b}; the product a*b (2*OP_W bits) is
//   delivered through a valid/ready handshake.
// Optional feature macro: FIFO_OVF_FLAG_EN (adds sticky ovf_flag output).
// Ports:
//   clk, rst           - rising-edge clock, async active-high reset
//   write_req          - push request (dropped when left_sig == 0)
//   fifo_write_data    - {a, b}, a in the upper OP_W bits
//   signed_mode        - pair is two's complement, stored with the entry
//   left_sig           - free FIFO entries (registered)
//   product            - a*b, held stable while product_valid
//   product_valid      - product available
//   product_ready      - consumer accepts product (only acts in DONE)
//   ovf_flag           - sticky push-while-full flag (FIFO_OVF_FLAG_EN only)
module fifo_multiplier_stream #(
  parameter int OP_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_req,
  input  logic [2*OP_W-1:0]         fifo_write_data,
  input  logic                      signed_mode,
  output logic [$clog2(DEPTH):0]    left_sig,
  output logic [2*OP_W-1:0]         product,
  output logic                      product_valid,
  input  logic                      product_ready
`ifdef FIFO_OVF_FLAG_EN
  ,
  output logic                      ovf_flag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 2 * OP_W;
  localparam int CW = $clog2(OP_W + 1);
  localparam logic [AW:0] ALL_FREE = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state;
  logic [PW:0]     mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop;

  logic [PW:0]     rd;
  logic [OP_W-1:0] a_raw, b_raw, a_mag, b_mag;
  logic            rd_signed;

  logic [PW-1:0]   mcand, acc;
  logic [OP_W-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            neg;

  // Push decision uses the pre-edge free count, so a push while full is
  // dropped even if a pop frees a slot on the same edge.
  assign push = write_req && (left_sig != '0);
  assign pop  = (state == IDLE) && (left_sig != ALL_FREE);

  assign rd        = mem[rptr];
  assign rd_signed = rd[PW];
  assign a_raw     = rd[PW-1:OP_W];
  assign b_raw     = rd[OP_W-1:0];
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude (2^(OP_W-1)).
  assign a_mag     = (rd_signed && a_raw[OP_W-1]) ? -a_raw : a_raw;
  assign b_mag     = (rd_signed && b_raw[OP_W-1]) ? -b_raw : b_raw;

  // Storage needs no reset: emptiness is defined by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {signed_mode, fifo_write_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      left_sig <= ALL_FREE;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   left_sig <= left_sig - 1'b1;
        2'b01:   left_sig <= left_sig + 1'b1;
        default: left_sig <= left_sig;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
      neg           <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mcand  <= {{OP_W{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= rd_signed & (a_raw[OP_W-1] ^ b_raw[OP_W-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(OP_W - 1)) state <= SIGN;
        end
        SIGN: begin
          product       <= neg ? -acc : acc;
          product_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (product_ready) begin
            product_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_OVF_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ovf_flag <= 1'b0;
    else if (write_req && left_sig == '0)  ovf_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_multiplier_stream.sv
// Testbench for fifo_multiplier_stream (OP_W=8, DEPTH=8): directed vectors,
// products collected on each new product_valid and compared in push order.
module tb_fifo_multiplier_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_req = 1'b0;
  logic [15:0] fifo_write_data = '0;
  logic        signed_mode = 1'b0;
  logic [3:0]  left_sig;
  logic [15:0] product;
  logic        product_valid;
  logic        product_ready = 1'b1;
`ifdef FIFO_OVF_FLAG_EN
  logic        ovf_flag;
`endif

  fifo_multiplier_stream #(.OP_W(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .write_req(write_req),
    .fifo_write_data(fifo_write_data),
    .signed_mode(signed_mode),
    .left_sig(left_sig),
    .product(product),
    .product_valid(product_valid),
    .product_ready(product_ready)
`ifdef FIFO_OVF_FLAG_EN
    ,
    .ovf_flag(ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Reference: low 2*OP_W bits of the product of the sign/zero-extended operands.
  function automatic logic [15:0] mdl(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return 16'(ea * eb);
  endfunction

  logic [15:0] exp_q[$];
  logic        pv_d      = 1'b0;
  int          run       = 0;
  bit          chk_run   = 0;
  bit          cap_first = 0;
  int          first_vcyc = 0;

  always @(negedge clk) begin
    if (product_valid && !pv_d) begin
      if (cap_first) begin first_vcyc = cyc; cap_first = 0; end
      if (exp_q.size() == 0) chk("unexp_valid", {31'd0, product_valid}, 32'd0);
      else                   chk("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
    end
    if (product_valid) run++;
    else begin
      if (pv_d && chk_run) chk("vld_1cyc", run, 1);
      run = 0;
    end
    pv_d = product_valid;
  end

  // Called at a negedge; drives one push across the next rising edge.
  task automatic push(input logic [15:0] d, input logic s, input bit track, input logic [15:0] e);
    write_req       = 1'b1;
    fifo_write_data = d;
    signed_mode     = s;
    if (track) exp_q.push_back(e);
    @(negedge clk);
    write_req = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n && !product_valid; i++) @(negedge clk);
    chk("valid_seen", {31'd0, product_valid}, 32'd1);
  endtask

  initial begin
    int t_cyc;
    logic [7:0] a, b;
    logic s;

    // 1. reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_left", left_sig, 8);
    chk("rst_prod", product, 0);
    chk("rst_vld", product_valid, 0);
`ifdef FIFO_OVF_FLAG_EN
    chk("rst_ovf", ovf_flag, 0);
`endif
    @(negedge clk);

    // 2. signed back-to-back, latency and one-cycle valid
    chk_run = 1; cap_first = 1;
    push({8'd45, 8'd2}, 1'b1, 1, 16'h005A);
    t_cyc = cyc;
    push({8'd23, 8'd12}, 1'b1, 1, 16'h0114);
    wait_drain(60);
    chk("lat_first", first_vcyc - t_cyc, 10);
    chk_run = 0;

    // 3. sign mode
    push({8'd15, 8'hFA}, 1'b1, 1, 16'hFFA6); wait_drain(40);
    push({8'd15, 8'hFA}, 1'b0, 1, 16'h0EA6); wait_drain(40);
    push({8'h80, 8'h80}, 1'b1, 1, 16'h4000); wait_drain(40);
    push({8'hFF, 8'hFF}, 1'b0, 1, 16'hFE01); wait_drain(40);

    // 1b. reset mid-CALC: in-flight product lost
    push({8'd9, 8'd9}, 1'b0, 0, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_left", left_sig, 8);
    chk("mid_rst_prod", product, 0);
    chk("mid_rst_vld", product_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_rst_idle_left", left_sig, 8);

    // 4. full FIFO with stalled consumer
    product_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = 8'(i * 3 + 1); b = 8'(i * 5 + 2);
      push({a, b}, 1'b0, i < 9, mdl(a, b, 1'b0));
    end
    chk("full_left", left_sig, 0);
`ifdef FIFO_OVF_FLAG_EN
    chk("ovf_set", ovf_flag, 1);
`endif
    product_ready = 1'b1;
    wait_drain(200);
    chk("drained_left", left_sig, 8);

    // 5. push on the pop edge at occupancy 3, then wrap pointers
    product_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'(i * 13 + 5); b = 8'(i * 7 + 131); s = i[0];
      push({a, b}, s, 1, mdl(a, b, s));
    end
    chk("occ3_left", left_sig, 5);
    wait_valid(30);
    product_ready = 1'b1;
    @(negedge clk);
    product_ready = 1'b0;
    a = 8'd200; b = 8'd77;
    push({a, b}, 1'b1, 1, mdl(a, b, 1'b1));
    chk("pushpop_left", left_sig, 5);
    product_ready = 1'b1;
    for (int i = 5; i < 20; i++) begin
      for (int k = 0; k < 20 && left_sig == 0; k++) @(negedge clk);
      a = 8'(i * 13 + 5); b = 8'(i * 7 + 131); s = i[0];
      push({a, b}, s, 1, mdl(a, b, s));
    end
    wait_drain(400);

    // 6. ready stall in DONE
    product_ready = 1'b0;
    push({8'd7, 8'd9}, 1'b0, 1, 16'h003F);
    wait_valid(30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_prod", product, 16'h003F);
      chk("stall_vld", product_valid, 1);
    end
    product_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_vld", product_valid, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
